// File: rtl/bp_be_regfile_mp_if.sv
// Signal bundle for bp_be_regfile_mp: writeback, read ports, cfg debug port and parity flag.
// Widths must match the parameters of the attached regfile.
interface bp_be_regfile_mp_if #(
    parameter int read_ports_p = 2,
    parameter int data_width_p = 64,
    parameter int addr_width_p = 5
);
    logic                                  cfg_w_v_i;
    logic                                  cfg_r_v_i;
    logic [addr_width_p-1:0]               cfg_addr_i;
    logic [data_width_p-1:0]               cfg_data_i;
    logic [data_width_p-1:0]               cfg_data_o;
    logic                                  rd_w_v_i;
    logic [addr_width_p-1:0]               rd_addr_i;
    logic [data_width_p-1:0]               rd_data_i;
    logic [read_ports_p-1:0]               rs_r_v_i;
    logic [read_ports_p*addr_width_p-1:0]  rs_addr_i;
    logic [read_ports_p*data_width_p-1:0]  rs_data_o;
    logic                                  parity_err_o;

    modport master (
        output cfg_w_v_i, cfg_r_v_i, cfg_addr_i, cfg_data_i,
        output rd_w_v_i, rd_addr_i, rd_data_i,
        output rs_r_v_i, rs_addr_i,
        input  cfg_data_o, rs_data_o, parity_err_o
    );

    modport slave (
        input  cfg_w_v_i, cfg_r_v_i, cfg_addr_i, cfg_data_i,
        input  rd_w_v_i, rd_addr_i, rd_data_i,
        input  rs_r_v_i, rs_addr_i,
        output cfg_data_o, rs_data_o, parity_err_o
    );
endinterface

// File: rtl/bp_be_regfile_mp.sv
// Multi-read-port register file with 1-cycle read latency, stall re-read, write forwarding and cfg port.
// Optional per-entry even parity is enabled by defining BP_BE_REGFILE_PARITY_EN.
module bp_be_regfile_mp #(
    parameter int read_ports_p = 2,
    parameter int data_width_p = 64,
    parameter int addr_width_p = 5,
    parameter bit zero_x0_p    = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    bp_be_regfile_mp_if.slave  bus
);
    localparam int els_lp = 2 ** addr_width_p;
`ifdef BP_BE_REGFILE_PARITY_EN
    localparam int word_width_lp = data_width_p + 1;
`else
    localparam int word_width_lp = data_width_p;
`endif

    typedef logic [addr_width_p-1:0] addr_t;
    typedef logic [data_width_p-1:0] data_t;

    if (read_ports_p < 1 || read_ports_p > 4) begin : g_bad_ports
        $error("bp_be_regfile_mp: read_ports_p must be in 1..4");
    end

    logic [word_width_lp-1:0] mem [els_lp];

    addr_t addr_r      [read_ports_p];
    addr_t addr_n      [read_ports_p];
    addr_t reread_addr [read_ports_p];
    data_t data_r      [read_ports_p];
    data_t data_n      [read_ports_p];
    logic  out_v_r;
    logic  out_en;
    logic  cfg_any;
    logic  w_v;
    addr_t w_addr;
    data_t w_data;
`ifdef BP_BE_REGFILE_PARITY_EN
    logic [read_ports_p-1:0] port_err;
    logic                    parity_err_r;
`endif

    // cfg write wins over writeback; writes to x0 vanish when x0 is hardwired
    always_comb begin
        cfg_any = bus.cfg_w_v_i | bus.cfg_r_v_i;
        w_addr  = bus.cfg_w_v_i ? bus.cfg_addr_i : bus.rd_addr_i;
        w_data  = bus.cfg_w_v_i ? bus.cfg_data_i : bus.rd_data_i;
        w_v     = (bus.cfg_w_v_i | bus.rd_w_v_i) & ~(zero_x0_p && (w_addr == '0));
    end

    always_ff @(posedge clk_i) begin
        if (w_v) begin
`ifdef BP_BE_REGFILE_PARITY_EN
            mem[w_addr] <= {^w_data, w_data};
`else
            mem[w_addr] <= w_data;
`endif
        end
    end

    always_comb begin
`ifdef BP_BE_REGFILE_PARITY_EN
        port_err = '0;
`endif
        for (int k = 0; k < read_ports_p; k++) begin
            addr_n[k]      = addr_r[k];
            data_n[k]      = data_r[k];
            reread_addr[k] = bus.rs_r_v_i[k] ? bus.rs_addr_i[k*addr_width_p +: addr_width_p]
                                             : addr_r[k];
            if (!cfg_any) begin
                if (bus.rs_r_v_i[k]) begin
                    addr_n[k] = reread_addr[k];
                end
                if (zero_x0_p && (reread_addr[k] == '0)) begin
                    data_n[k] = '0;
                end else if (bus.rd_w_v_i && (bus.rd_addr_i == reread_addr[k])) begin
                    data_n[k] = bus.rd_data_i;
                end else begin
                    data_n[k] = mem[reread_addr[k]][data_width_p-1:0];
`ifdef BP_BE_REGFILE_PARITY_EN
                    port_err[k] = ^mem[reread_addr[k]];
`endif
                end
            end else if ((k == 0) && bus.cfg_r_v_i) begin
                // debug read borrows port 0 without disturbing its held address
                if (zero_x0_p && (bus.cfg_addr_i == '0)) begin
                    data_n[k] = '0;
                end else if (bus.cfg_w_v_i) begin
                    data_n[k] = bus.cfg_data_i;
                end else begin
                    data_n[k] = mem[bus.cfg_addr_i][data_width_p-1:0];
`ifdef BP_BE_REGFILE_PARITY_EN
                    port_err[k] = ^mem[bus.cfg_addr_i];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_v_r <= 1'b0;
            for (int k = 0; k < read_ports_p; k++) begin
                addr_r[k] <= '0;
                data_r[k] <= '0;
            end
        end else begin
            out_v_r <= 1'b1;
            addr_r  <= addr_n;
            data_r  <= data_n;
        end
    end

    assign out_en = out_v_r & ~reset_i;

    for (genvar k = 0; k < read_ports_p; k++) begin : g_out
        assign bus.rs_data_o[k*data_width_p +: data_width_p] = out_en ? data_r[k] : '0;
    end
    assign bus.cfg_data_o = out_en ? data_r[0] : '0;

`ifdef BP_BE_REGFILE_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            parity_err_r <= 1'b0;
        end else if (|port_err) begin
            parity_err_r <= 1'b1;
        end
    end
    assign bus.parity_err_o = parity_err_r;
`else
    assign bus.parity_err_o = 1'b0;
`endif

    // a writeback colliding with a cfg write is silently lost
    a_no_cfg_rd_collision : assert property (@(posedge clk_i) disable iff (reset_i)
        !(bus.cfg_w_v_i && bus.rd_w_v_i))
        else $error("bp_be_regfile_mp: rd write dropped by simultaneous cfg write");
endmodule

// File: tb/tb_bp_be_regfile_mp.sv
// Directed bench for bp_be_regfile_mp: one x0-hardwired instance and one ordinary-x0 instance.
// Parity checks run only when BP_BE_REGFILE_PARITY_EN is defined.
module tb_bp_be_regfile_mp;
    localparam int rp = 2;
    localparam int dw = 64;
    localparam int aw = 5;

    logic clk_i = 1'b0;
    logic reset_i;
    int   checks = 0;
    int   passed = 0;

    always #5 clk_i = ~clk_i;

    bp_be_regfile_mp_if #(.read_ports_p(rp), .data_width_p(dw), .addr_width_p(aw)) bus ();
    bp_be_regfile_mp_if #(.read_ports_p(rp), .data_width_p(dw), .addr_width_p(aw)) bus_nz ();

    bp_be_regfile_mp #(.read_ports_p(rp), .data_width_p(dw), .addr_width_p(aw), .zero_x0_p(1'b1)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    bp_be_regfile_mp #(.read_ports_p(rp), .data_width_p(dw), .addr_width_p(aw), .zero_x0_p(1'b0)) dut_nz (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus_nz)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, observed, expected);
    endtask

    task automatic driveBus(input logic cfg_w, input logic cfg_r, input logic [aw-1:0] cfg_addr,
                            input logic [dw-1:0] cfg_data, input logic rd_w, input logic [aw-1:0] rd_addr,
                            input logic [dw-1:0] rd_data, input logic [rp-1:0] rs_v,
                            input logic [aw-1:0] a0, input logic [aw-1:0] a1);
        bus.cfg_w_v_i     = cfg_w;    bus_nz.cfg_w_v_i  = cfg_w;
        bus.cfg_r_v_i     = cfg_r;    bus_nz.cfg_r_v_i  = cfg_r;
        bus.cfg_addr_i    = cfg_addr; bus_nz.cfg_addr_i = cfg_addr;
        bus.cfg_data_i    = cfg_data; bus_nz.cfg_data_i = cfg_data;
        bus.rd_w_v_i      = rd_w;     bus_nz.rd_w_v_i   = rd_w;
        bus.rd_addr_i     = rd_addr;  bus_nz.rd_addr_i  = rd_addr;
        bus.rd_data_i     = rd_data;  bus_nz.rd_data_i  = rd_data;
        bus.rs_r_v_i      = rs_v;     bus_nz.rs_r_v_i   = rs_v;
        bus.rs_addr_i     = {a1, a0}; bus_nz.rs_addr_i  = {a1, a0};
    endtask

    // drive one cycle of pipeline traffic, return 1ns after the capturing edge
    task automatic applyStimulus(input logic rd_w, input logic [aw-1:0] rd_addr, input logic [dw-1:0] rd_data,
                                 input logic [rp-1:0] rs_v, input logic [aw-1:0] a0, input logic [aw-1:0] a1);
        driveBus(1'b0, 1'b0, '0, '0, rd_w, rd_addr, rd_data, rs_v, a0, a1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyCfg(input logic cfg_w, input logic cfg_r, input logic [aw-1:0] addr, input logic [dw-1:0] data);
        driveBus(cfg_w, cfg_r, addr, data, 1'b0, '0, '0, '0, '0, '0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        driveBus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0, '0);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        checkOutput("reset_p0", bus.rs_data_o[63:0], 64'h0);
        checkOutput("reset_p1", bus.rs_data_o[127:64], 64'h0);
        checkOutput("reset_parity", {63'h0, bus.parity_err_o}, 64'h0);
        reset_i = 1'b0;
        #1;
        checkOutput("first_cycle_p0", bus.rs_data_o[63:0], 64'h0);
        checkOutput("first_cycle_cfg", bus.cfg_data_o, 64'h0);

        // basic write then read on port 1
        applyStimulus(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 2'b00, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 64'h0, 2'b10, 5'd0, 5'd5);
        checkOutput("basic_p1", bus.rs_data_o[127:64], 64'hDEAD_BEEF_0000_0001);
        checkOutput("basic_p0_x0", bus.rs_data_o[63:0], 64'h0);

        // write->read forwarding on port 0 while port 1 re-reads x5
        applyStimulus(1'b1, 5'd7, 64'h1234, 2'b01, 5'd7, 5'd0);
        checkOutput("fwd_p0", bus.rs_data_o[63:0], 64'h1234);
        checkOutput("fwd_p1_hold", bus.rs_data_o[127:64], 64'hDEAD_BEEF_0000_0001);
        applyStimulus(1'b0, 5'd0, 64'h0, 2'b10, 5'd0, 5'd7);
        checkOutput("fwd_array_p1", bus.rs_data_o[127:64], 64'h1234);
        checkOutput("fwd_stall_p0", bus.rs_data_o[63:0], 64'h1234);

        // stall re-read sees a later write one cycle afterwards
        applyStimulus(1'b1, 5'd9, 64'h10, 2'b00, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 64'h0, 2'b01, 5'd9, 5'd0);
        checkOutput("stall_issue", bus.rs_data_o[63:0], 64'h10);
        applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 5'd0, 5'd0);
        checkOutput("stall_hold", bus.rs_data_o[63:0], 64'h10);
        applyStimulus(1'b1, 5'd9, 64'h20, 2'b00, 5'd0, 5'd0);
        checkOutput("stall_update", bus.rs_data_o[63:0], 64'h20);
        applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 5'd0, 5'd0);
        checkOutput("stall_after", bus.rs_data_o[63:0], 64'h20);

        // cfg strobes freeze the read ports for their cycle
        applyCfg(1'b1, 1'b0, 5'd9, 64'h777);
        checkOutput("cfg_w_hold_p0", bus.rs_data_o[63:0], 64'h20);
        checkOutput("cfg_w_hold_p1", bus.rs_data_o[127:64], 64'h1234);
        applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 5'd0, 5'd0);
        checkOutput("cfg_w_reread", bus.rs_data_o[63:0], 64'h777);
        applyCfg(1'b1, 1'b0, 5'd3, 64'hABC);
        applyCfg(1'b0, 1'b1, 5'd3, 64'h0);
        checkOutput("cfg_r_x3", bus.cfg_data_o, 64'hABC);
        checkOutput("cfg_r_port0", bus.rs_data_o[63:0], 64'hABC);
        checkOutput("cfg_r_p1_hold", bus.rs_data_o[127:64], 64'h1234);
        applyCfg(1'b1, 1'b1, 5'd4, 64'hBEEF);
        checkOutput("cfg_wr_same", bus.cfg_data_o, 64'hBEEF);
        applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 5'd0, 5'd0);
        checkOutput("cfg_addr_kept", bus.rs_data_o[63:0], 64'h777);

        // forwarding applies to every matching port
        applyStimulus(1'b1, 5'd11, 64'hAA, 2'b11, 5'd11, 5'd11);
        checkOutput("dual_fwd_p0", bus.rs_data_o[63:0], 64'hAA);
        checkOutput("dual_fwd_p1", bus.rs_data_o[127:64], 64'hAA);

        // x0 hardwired vs ordinary
        applyStimulus(1'b1, 5'd0, 64'hFF, 2'b00, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 64'h0, 2'b11, 5'd0, 5'd0);
        checkOutput("x0_p0", bus.rs_data_o[63:0], 64'h0);
        checkOutput("x0_p1", bus.rs_data_o[127:64], 64'h0);
        checkOutput("nz_x0_p0", bus_nz.rs_data_o[63:0], 64'hFF);
        checkOutput("nz_x0_p1", bus_nz.rs_data_o[127:64], 64'hFF);
        applyStimulus(1'b1, 5'd0, 64'h55, 2'b11, 5'd0, 5'd0);
        checkOutput("x0_over_fwd", bus.rs_data_o[63:0], 64'h0);
        checkOutput("nz_x0_fwd", bus_nz.rs_data_o[63:0], 64'h55);

        // reset mid-stall drops the held address
        applyStimulus(1'b0, 5'd0, 64'h0, 2'b01, 5'd5, 5'd0);
        checkOutput("prestall_p0", bus.rs_data_o[63:0], 64'hDEAD_BEEF_0000_0001);
        driveBus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0, '0);
        reset_i = 1'b1;
        #1;
        checkOutput("rst_high_p0", bus.rs_data_o[63:0], 64'h0);
        checkOutput("rst_high_cfg", bus.cfg_data_o, 64'h0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        #1;
        checkOutput("rst_first_p0", bus_nz.rs_data_o[63:0], 64'h0);
        checkOutput("rst_first_p1", bus_nz.rs_data_o[127:64], 64'h0);
        applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 5'd0, 5'd0);
        checkOutput("rst_discard_p0", bus.rs_data_o[63:0], 64'h0);
        checkOutput("rst_discard_nz_p0", bus_nz.rs_data_o[63:0], 64'h55);

`ifdef BP_BE_REGFILE_PARITY_EN
        applyStimulus(1'b1, 5'd12, 64'h3, 2'b00, 5'd0, 5'd0);
        dut.mem[12][0] = ~dut.mem[12][0];
        applyStimulus(1'b1, 5'd12, 64'h3, 2'b10, 5'd0, 5'd12);
        checkOutput("par_fwd_data", bus.rs_data_o[127:64], 64'h3);
        checkOutput("par_fwd_clean", {63'h0, bus.parity_err_o}, 64'h0);
        dut.mem[12][0] = ~dut.mem[12][0];
        applyStimulus(1'b0, 5'd0, 64'h0, 2'b10, 5'd0, 5'd12);
        checkOutput("par_bad_data", bus.rs_data_o[127:64], 64'h2);
        checkOutput("par_err_set", {63'h0, bus.parity_err_o}, 64'h1);
        applyStimulus(1'b0, 5'd0, 64'h0, 2'b10, 5'd0, 5'd5);
        checkOutput("par_err_sticky", {63'h0, bus.parity_err_o}, 64'h1);
`else
        checkOutput("parity_tied_off", {63'h0, bus.parity_err_o}, 64'h0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
